alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Registered execute stage on the consuming end of the ALU-control interface.
- Takes operand A, operand B, carry-in, the 4-bit `OP_*` opcode and the store_carry/store_overflow strobes, and produces a registered result.
- Holds the architectural carry and overflow flags and feeds carry back to ALU control for CARRY/BORROW.
- Sits between operand selection and stack writeback, with valid/ready handshakes on both sides.

Parameters:
- WORD_WIDTH, 32, datapath width; must be a power of two ≥ 8.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept
- alu_a  input  WORD_WIDTH  operand A
- alu_b  input  WORD_WIDTH  operand B / shift amount
- alu_ic  input  1  carry-in for OP_ADD (may be X for other ops)
- alu_opcode  input  4  `OP_*` code
- store_carry  input  1  update carry flag on accept
- store_overflow  input  1  update overflow flag on accept
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes result
- result  output  WORD_WIDTH  registered result
- result_zero  output  1  registered result == 0
- carry  output  1  carry flag register
- overflow  output  1  overflow flag register
- flags_we  input  1  direct flag write (context restore)
- flags_in  input  2  {overflow, carry} value for flags_we

Behaviour:
- Reset (async, reset_n low):
  - out_valid=0, result=0, result_zero=1, carry=0, overflow=0.
  - in_ready=1 is combinational, so it follows out_valid=0.
  - A pending result is dropped.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - Accept = in_valid & in_ready.
  - Latency is 1 cycle: an op accepted at edge N is visible on result at N+1.
  - Full throughput when out_ready=1.
  - With out_valid=1 and out_ready=0, result, out_valid and result_zero hold; in_ready=0.
  - out_valid clears on out_ready when nothing new is accepted.
- Two-state output FSM:
  - EMPTY → FULL on accept of a non-NOP op.
  - FULL → FULL on out_ready & accept of a non-NOP op.
  - FULL → EMPTY on out_ready & no accept (or accept of NOP).
- OP_NOP, or any undefined code:
  - Consumed when accepted; no result is produced.
  - Flags are not updated, regardless of strobes.
- OP_ADD:
  - sum = a + b + ic, computed at WORD_WIDTH+1 bits.
  - result = sum[W-1:0]; carry_next = sum[W].
  - ovf_next = (a[W-1]==b[W-1]) & (result[W-1]!=a[W-1]).
  - Subtraction arrives as a + ~b + 1.
- Logic ops: OP_AND, OP_OR, OP_XOR are bitwise a op b.
- Shifts (a is the value, b is the unsigned amount):
  - OP_LSL / OP_LSR: result 0 when b ≥ W.
  - OP_ASR: saturates to all sign bits when b ≥ W.
  - OP_CSL / OP_CSR: rotate by b[log2(W)-1:0], so negative amounts wrap, e.g. CSL by -1 is CSR by 1.
- Non-ADD flag results: carry_next=0 and ovf_next=0. They are written only if the corresponding strobe is set.
- Flag update at the edge:
  - carry <= carry_next when accept & store_carry & op is ADD.
  - overflow <= ovf_next under the same condition with store_overflow.
  - The strobes are independent of each other.
- Flag write priority:
  - flags_we has priority over an accepted op's strobes in the same cycle.
  - The result is still produced.
- Flag timing:
  - carry/overflow are registered with no combinational bypass.
  - An op accepted the cycle after a flag-updating op sees the updated carry on the carry output.
- Flags update on accept, not on result consumption; they are unaffected by out_ready backpressure.

Test Plan:
- Reset → out_valid=0, result=0, result_zero=1, carry=0, overflow=0, in_ready=1.
- ADD with a=0x7FFFFFFF, b=1, ic=0, both strobes set → next cycle result=0x80000000, carry=0, overflow=1.
- ADD with a=0xFFFFFFFF, b=0, ic=1, both strobes set → result=0, result_zero=1, carry=1, overflow=0.
- Repeat that ADD with strobes clear → flags keep their prior values.
- Shifts on a=0x80000001:
  - LSL b=33 → result=0.
  - ASR b=40 → result=0xFFFFFFFF.
  - CSL b=0xFFFFFFFF → result=0xC0000000.
  - LSR b=4 → result=0x08000000.
- Backpressure:
  - Issue three back-to-back ADDs with out_ready=0 after the first.
  - Required: in_ready drops and result holds the first value.
  - On out_ready=1: results appear in order, one per cycle, none lost.
- NOP with strobes set, mid-stream → no out_valid pulse and no flag change.
- flags_we=1, flags_in=2'b01, same cycle as a carry-clearing ADD → carry=1, overflow=0.
- reset_n low while FULL → result dropped and flags cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage.
// Accepts one operation per cycle over a valid/ready handshake and holds the
// result in an output register until the consumer takes it. It also owns the
// architectural carry and overflow flags.
// Opcode map: NOP=0 ADD=1 AND=2 OR=3 XOR=4 LSL=5 LSR=6 ASR=7 CSL=8 CSR=9.
// Any other code behaves like NOP.
module alu_exec_stage #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] alu_a,
    input  logic [WORD_WIDTH-1:0] alu_b,
    input  logic                  alu_ic,
    input  logic [3:0]            alu_opcode,
    input  logic                  store_carry,
    input  logic                  store_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  result_zero,
    output logic                  carry,
    output logic                  overflow,
    input  logic                  flags_we,
    input  logic [1:0]            flags_in
);

    localparam int W  = WORD_WIDTH;
    localparam int SW = $clog2(WORD_WIDTH);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LSL = 4'h5;
    localparam logic [3:0] OP_LSR = 4'h6;
    localparam logic [3:0] OP_ASR = 4'h7;
    localparam logic [3:0] OP_CSL = 4'h8;
    localparam logic [3:0] OP_CSR = 4'h9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Rotate left by n.
    // The high half of the doubled word holds the rotated value.
    function automatic logic [W-1:0] rot_left(input logic [W-1:0] v, input logic [SW-1:0] n);
        logic [2*W-1:0] t;
        t = {v, v} << n;
        return t[2*W-1:W];
    endfunction

    // Rotate right by n.
    // The low half of the doubled word holds the rotated value.
    function automatic logic [W-1:0] rot_right(input logic [W-1:0] v, input logic [SW-1:0] n);
        logic [2*W-1:0] t;
        t = {v, v} >> n;
        return t[W-1:0];
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   result_q;
    logic           zero_q;
    logic           carry_q;
    logic           ovf_q;

    logic [W:0]     sum_s;
    logic [W-1:0]   res_s;
    logic           op_valid_s;
    logic           c_next_s;
    logic           o_next_s;
    logic [SW-1:0]  sh_s;
    logic           big_s;
    logic           accept_s;
    logic           produce_s;
    logic           is_add_s;

    assign sum_s = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ic};
    assign sh_s  = alu_b[SW-1:0];
    // Because W is a power of two, any set bit above the rotate field means b >= W.
    assign big_s = |alu_b[W-1:SW];

    assign in_ready  = (state_q == ST_EMPTY) | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign is_add_s  = (alu_opcode == OP_ADD);
    assign produce_s = accept_s & op_valid_s;

    // Datapath: compute the candidate result and flag values for the presented op.
    always_comb begin
        res_s      = {W{1'b0}};
        op_valid_s = 1'b1;
        c_next_s   = 1'b0;
        o_next_s   = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                res_s    = sum_s[W-1:0];
                c_next_s = sum_s[W];
                o_next_s = (alu_a[W-1] == alu_b[W-1]) & (sum_s[W-1] != alu_a[W-1]);
            end
            OP_AND: res_s = alu_a & alu_b;
            OP_OR:  res_s = alu_a | alu_b;
            OP_XOR: res_s = alu_a ^ alu_b;
            OP_LSL: begin
                if (big_s) res_s = {W{1'b0}};
                else       res_s = alu_a << sh_s;
            end
            OP_LSR: begin
                if (big_s) res_s = {W{1'b0}};
                else       res_s = alu_a >> sh_s;
            end
            OP_ASR: begin
                if (big_s) res_s = {W{alu_a[W-1]}};
                else       res_s = $signed(alu_a) >>> sh_s;
            end
            OP_CSL: res_s = rot_left(alu_a, sh_s);
            OP_CSR: res_s = rot_right(alu_a, sh_s);
            OP_NOP: op_valid_s = 1'b0;
            default: op_valid_s = 1'b0;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // Output FSM next state.
    // A NOP that is accepted while FULL drains the stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (produce_s) state_d = ST_FULL;
                else           state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_ready) state_d = produce_s ? ST_FULL : ST_EMPTY;
                else           state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output FSM outputs: out_valid is a decode of the state register only.
    always_comb begin
        out_valid = 1'b0;
        case (state_q)
            ST_EMPTY: out_valid = 1'b0;
            ST_FULL:  out_valid = 1'b1;
            default:  out_valid = 1'b0;
        endcase
    end

    // Result register.
    // It is loaded only when an accepted op produces a result, and otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= {W{1'b0}};
            zero_q   <= 1'b1;
        end else if (produce_s) begin
            result_q <= res_s;
            zero_q   <= (res_s == {W{1'b0}});
        end else begin
            result_q <= result_q;
            zero_q   <= zero_q;
        end
    end

    // Architectural flags.
    // A direct write wins over an accepted ADD's strobes.
    // The flags update on accept and are independent of out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flags_we) begin
            ovf_q   <= flags_in[1];
            carry_q <= flags_in[0];
        end else begin
            if (accept_s & is_add_s & store_carry)    carry_q <= c_next_s;
            else                                      carry_q <= carry_q;
            if (accept_s & is_add_s & store_overflow) ovf_q   <= o_next_s;
            else                                      ovf_q   <= ovf_q;
        end
    end

    assign result      = result_q;
    assign result_zero = zero_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage (WORD_WIDTH = 32).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_alu_exec_stage;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LSL = 4'h5;
    localparam logic [3:0] OP_LSR = 4'h6;
    localparam logic [3:0] OP_ASR = 4'h7;
    localparam logic [3:0] OP_CSL = 4'h8;
    localparam logic [3:0] OP_CSR = 4'h9;
    localparam logic [3:0] OP_BAD = 4'hF;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ic;
    logic [3:0]  alu_opcode;
    logic        store_carry;
    logic        store_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_zero;
    logic        carry;
    logic        overflow;
    logic        flags_we;
    logic [1:0]  flags_in;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_stage #(.WORD_WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ic         (alu_ic),
        .alu_opcode     (alu_opcode),
        .store_carry    (store_carry),
        .store_overflow (store_overflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .result_zero    (result_zero),
        .carry          (carry),
        .overflow       (overflow),
        .flags_we       (flags_we),
        .flags_in       (flags_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ic;
        logic        sc;
        logic        so;
        logic [31:0] er;
        logic        ez;
        logic        ec;
        logic        eo;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ic, input logic sc, input logic so);
        in_valid       = 1'b1;
        alu_opcode     = op;
        alu_a          = a;
        alu_b          = b;
        alu_ic         = ic;
        store_carry    = sc;
        store_overflow = so;
    endtask

    initial begin
        // Flag expectations accumulate down the table, starting from reset (c0 o0).
        vecs[0]  = '{"add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"add_carry",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"add_nostb",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{"add_nostb2", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"add_c_only", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"add_o_only", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{"lsl33",      OP_LSL, 32'h8000_0001, 32'd33,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{"asr40",      OP_ASR, 32'h8000_0001, 32'd40,        1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"csl_m1",     OP_CSL, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hC000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"lsr4",       OP_LSR, 32'h8000_0001, 32'd4,         1'b0, 1'b0, 1'b0, 32'h0800_0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{"lsl31",      OP_LSL, 32'h8000_0001, 32'd31,        1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"lsr32",      OP_LSR, 32'h8000_0001, 32'd32,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{"asr4",       OP_ASR, 32'h8000_0001, 32'd4,         1'b0, 1'b0, 1'b0, 32'hF800_0000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{"csr4",       OP_CSR, 32'h8000_0001, 32'd4,         1'b0, 1'b0, 1'b0, 32'h1800_0000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{"and",        OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 32'hF000_F000, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{"or",         OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{"xor",        OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{"sub_5_3",    OP_ADD, 32'h0000_0005, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{"sub_3_5",    OP_ADD, 32'h0000_0003, 32'hFFFF_FFFA, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{"sub_min",    OP_ADD, 32'h8000_0000, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{"asr_pos_big", OP_ASR, 32'h7FFF_FFFF, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        reset_n        = 1'b0;
        in_valid       = 1'b0;
        alu_a          = 32'h0;
        alu_b          = 32'h0;
        alu_ic         = 1'b0;
        alu_opcode     = OP_NOP;
        store_carry    = 1'b0;
        store_overflow = 1'b0;
        out_ready      = 1'b1;
        flags_we       = 1'b0;
        flags_in       = 2'b00;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'd0, result_zero}, 32'd1);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors: one op, then one idle cycle
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ic, vecs[i].sc, vecs[i].so);
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].nm, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({vecs[i].nm, "_result"}, result, vecs[i].er);
            chk({vecs[i].nm, "_zero"}, {31'd0, result_zero}, {31'd0, vecs[i].ez});
            chk({vecs[i].nm, "_carry"}, {31'd0, carry}, {31'd0, vecs[i].ec});
            chk({vecs[i].nm, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[i].eo});
        end
        // Flags are now c1 o1.

        // Backpressure: three ADDs, consumer stalls after the first
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_first_result", result, 32'd2);
        out_ready = 1'b0;
        drive(OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_hold_result", result, 32'd2);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_hold2_result", result, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_second_result", result, 32'd30);
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        drive(OP_ADD, 32'd100, 32'd200, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_third_result", result, 32'd300);
        chk("bp_third_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_flags_carry", {31'd0, carry}, 32'd1);
        chk("bp_flags_ovf", {31'd0, overflow}, 32'd1);

        // NOP and undefined opcode mid-stream, with the strobes set
        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("nop_pre_result", result, 32'd0);
        chk("nop_pre_carry", {31'd0, carry}, 32'd1);
        chk("nop_pre_ovf", {31'd0, overflow}, 32'd0);
        drive(OP_NOP, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("nop_valid", {31'd0, out_valid}, 32'd0);
        chk("nop_carry", {31'd0, carry}, 32'd1);
        chk("nop_ovf", {31'd0, overflow}, 32'd0);
        drive(OP_BAD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("undef_valid", {31'd0, out_valid}, 32'd0);
        chk("undef_carry", {31'd0, carry}, 32'd1);
        chk("undef_ovf", {31'd0, overflow}, 32'd0);
        drive(OP_ADD, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_nop_valid", {31'd0, out_valid}, 32'd1);
        chk("post_nop_result", result, 32'd5);
        drive(OP_ADD, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("thru_valid", {31'd0, out_valid}, 32'd1);
        chk("thru_result", result, 32'd13);
        in_valid = 1'b0;

        // Direct flag write beats a carry-clearing ADD in the same cycle
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1);
        flags_we = 1'b1;
        flags_in = 2'b01;
        @(negedge clk);
        chk("fwe_carry", {31'd0, carry}, 32'd1);
        chk("fwe_ovf", {31'd0, overflow}, 32'd0);
        chk("fwe_result", result, 32'd2);
        chk("fwe_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        flags_in = 2'b10;
        @(negedge clk);
        chk("fwe2_carry", {31'd0, carry}, 32'd0);
        chk("fwe2_ovf", {31'd0, overflow}, 32'd1);
        flags_we = 1'b0;

        // Asynchronous reset while FULL
        @(negedge clk);
        drive(OP_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("arst_pre_result", result, 32'd1);
        chk("arst_pre_carry", {31'd0, carry}, 32'd1);
        chk("arst_pre_ovf", {31'd0, overflow}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_zero", {31'd0, result_zero}, 32'd1);
        chk("arst_carry", {31'd0, carry}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
